// File: rtl/led_pkg.sv
// ---------------------------------------------------------------------------
// led_pkg
// Shared definitions for the badge LED frame store and the pattern sources
// that feed it.
//   - Logical colour codes (red/green/blue).
//   - Default LED column / sink row counts.
//   - LED_MAP_PROD: logical colour driven on each physical sink row of each
//     LED. Field for (led l, row r) lives at [(l*rows + r)*2 +: 2].
//   - Frame buffer FSM state encoding.
//   - lin_index(): (led,row) -> linear storage index.
// ---------------------------------------------------------------------------
package led_pkg;

    localparam int DEFAULT_NUM_LEDS = 11;
    localparam int DEFAULT_NUM_ROWS = 3;

    localparam logic [1:0] COLOR_RED   = 2'd0;
    localparam logic [1:0] COLOR_GREEN = 2'd1;
    localparam logic [1:0] COLOR_BLUE  = 2'd2;

    // Per-LED row orders, packed {row C, row B, row A} so row A sits in the LSBs.
    localparam logic [5:0] ORDER_RGB = {COLOR_BLUE, COLOR_GREEN, COLOR_RED};
    localparam logic [5:0] ORDER_BGR = {COLOR_RED,  COLOR_GREEN, COLOR_BLUE};
    localparam logic [5:0] ORDER_GRB = {COLOR_BLUE, COLOR_RED,   COLOR_GREEN};

    // LED 10 in the MSBs down to LED 0 in the LSBs.
    localparam logic [2*DEFAULT_NUM_ROWS*DEFAULT_NUM_LEDS-1:0] LED_MAP_PROD = {
        ORDER_RGB,  // LED 10
        ORDER_RGB,  // LED 9
        ORDER_GRB,  // LED 8
        ORDER_GRB,  // LED 7
        ORDER_BGR,  // LED 6
        ORDER_BGR,  // LED 5
        ORDER_RGB,  // LED 4
        ORDER_BGR,  // LED 3
        ORDER_RGB,  // LED 2
        ORDER_BGR,  // LED 1
        ORDER_RGB   // LED 0
    };

    typedef enum logic [1:0] {
        ST_CLEAR     = 2'd0,
        ST_IDLE      = 2'd1,
        ST_SWAP_WAIT = 2'd2,
        ST_COPY      = 2'd3
    } fb_state_t;

    // Linear storage index for a physical (led,row) pair.
    function automatic logic [5:0] lin_index(input logic [3:0] led,
                                             input logic [1:0] row,
                                             input int         rows);
        return 6'(32'(led) * 32'(rows) + 32'(row));
    endfunction

endpackage

// File: rtl/led_color_map.sv
// ---------------------------------------------------------------------------
// led_color_map
// Combinational lookup of the physical sink row that carries a given logical
// colour on a given LED. o_valid is low for colour 3, for an LED index
// outside 0..NUM_LEDS-1, or when no row of that LED carries the colour.
// Ports:
//   i_led    LED index
//   i_color  logical colour (0=red, 1=green, 2=blue)
//   o_row    physical row carrying that colour (0 when invalid)
//   o_valid  lookup succeeded
// ---------------------------------------------------------------------------
module led_color_map
    import led_pkg::*;
#(
    parameter int                                  NUM_LEDS = DEFAULT_NUM_LEDS,
    parameter int                                  NUM_ROWS = DEFAULT_NUM_ROWS,
    parameter logic [2*NUM_ROWS*NUM_LEDS-1:0]      LED_MAP  = LED_MAP_PROD
) (
    input  logic [3:0] i_led,
    input  logic [1:0] i_color,
    output logic [1:0] o_row,
    output logic       o_valid
);

    // One match flag per (led,row): does that row carry the requested colour?
    logic [NUM_LEDS*NUM_ROWS-1:0] w_hit;

    genvar gi, gr;
    generate
        for (gi = 0; gi < NUM_LEDS; gi++) begin : g_led
            for (gr = 0; gr < NUM_ROWS; gr++) begin : g_row
                assign w_hit[gi*NUM_ROWS + gr] =
                    (LED_MAP[(gi*NUM_ROWS + gr)*2 +: 2] == i_color);
            end
        end
    endgenerate

    // Scan rows high to low so that, should a map ever list a colour twice,
    // the lowest row wins.
    always_comb begin
        o_row   = '0;
        o_valid = 1'b0;
        if ((i_color != 2'd3) && (32'(i_led) < 32'(NUM_LEDS))) begin
            for (int r = NUM_ROWS - 1; r >= 0; r--) begin
                if (w_hit[32'(i_led) * 32'(NUM_ROWS) + 32'(r)]) begin
                    o_row   = 2'(r);
                    o_valid = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/led_frame_buffer.sv
// ---------------------------------------------------------------------------
// led_frame_buffer
// Double-buffered RGB frame store in front of the LED PWM scanner. Pattern
// writes (led, logical colour, value) are remapped to the physical sink row
// and land in the back bank. A commit request waits for the scanner's frame
// boundary, swaps banks there, then copies the new front bank into the new
// back bank so later writes are incremental updates of the shown frame.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   wr_valid/ready   write handshake (ready only while idle)
//   wr_led/color/value  write payload
//   wr_err           1-cycle pulse: accepted write was out of range, dropped
//   commit           request a back->front swap
//   commit_done      1-cycle pulse on the edge the swap happens
//   frame_start      scanner frame boundary pulse
//   rd_led/rd_row    scanner read address (physical row)
//   rd_data          front-bank value, one cycle after the address
// ---------------------------------------------------------------------------
module led_frame_buffer
    import led_pkg::*;
#(
    parameter int                             NUM_LEDS = DEFAULT_NUM_LEDS,
    parameter int                             NUM_ROWS = DEFAULT_NUM_ROWS,
    parameter logic [2*NUM_ROWS*NUM_LEDS-1:0] LED_MAP  = LED_MAP_PROD
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [3:0] wr_led,
    input  logic [1:0] wr_color,
    input  logic [7:0] wr_value,
    output logic       wr_err,
    input  logic       commit,
    output logic       commit_done,
    input  logic       frame_start,
    input  logic [3:0] rd_led,
    input  logic [1:0] rd_row,
    output logic [7:0] rd_data
);

    localparam int         DEPTH    = NUM_LEDS * NUM_ROWS;
    localparam logic [5:0] LAST_IDX = 6'(DEPTH - 1);

    // State
    fb_state_t  r_state;
    fb_state_t  w_state_next;
    logic [5:0] r_cnt;
    logic [5:0] w_cnt_next;
    logic       r_front_sel;
    logic       r_wr_err;
    logic       r_commit_done;
    logic [7:0] r_rd_data;

    // Two banks, indexed [bank][led*NUM_ROWS+row].
    logic [7:0] r_mem [2][DEPTH];

    // Write-side wires
    logic       w_wr_ready;
    logic       w_swap;
    logic [1:0] w_map_row;
    logic       w_map_valid;
    logic       w_wr_fire;
    logic       w_wr_good;
    logic [5:0] w_wr_idx;
    logic [5:0] w_waddr;
    logic [7:0] w_wdata;
    logic [1:0] w_we;

    // Read-side wires
    logic       w_rd_in_range;
    logic [5:0] w_rd_idx;

    // -----------------------------------------------------------------------
    // Colour -> physical row lookup for the write port
    // -----------------------------------------------------------------------
    led_color_map #(
        .NUM_LEDS (NUM_LEDS),
        .NUM_ROWS (NUM_ROWS),
        .LED_MAP  (LED_MAP)
    ) u_color_map (
        .i_led   (wr_led),
        .i_color (wr_color),
        .o_row   (w_map_row),
        .o_valid (w_map_valid)
    );

    // -----------------------------------------------------------------------
    // FSM: next state, sweep counter, handshake
    // -----------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_wr_ready   = 1'b0;
        w_swap       = 1'b0;
        case (r_state)
            ST_CLEAR, ST_COPY: begin
                // Sweep every index once, then stop; the counter never wraps.
                if (r_cnt == LAST_IDX) begin
                    w_state_next = ST_IDLE;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + 6'd1;
                end
            end
            ST_IDLE: begin
                w_wr_ready = 1'b1;
                if (commit) begin
                    w_state_next = ST_SWAP_WAIT;
                end
            end
            ST_SWAP_WAIT: begin
                if (frame_start) begin
                    w_swap       = 1'b1;
                    w_state_next = ST_COPY;
                    w_cnt_next   = '0;
                end
            end
            default: begin
                w_state_next = ST_CLEAR;
                w_cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_CLEAR;
            r_cnt         <= '0;
            r_front_sel   <= 1'b0;
            r_wr_err      <= 1'b0;
            r_commit_done <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_cnt         <= w_cnt_next;
            r_wr_err      <= w_wr_fire & ~w_map_valid;
            r_commit_done <= w_swap;
            if (w_swap) begin
                r_front_sel <= ~r_front_sel;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Bank write port
    // -----------------------------------------------------------------------
    assign w_wr_fire = wr_valid & w_wr_ready;
    assign w_wr_good = w_wr_fire & w_map_valid;
    assign w_wr_idx  = lin_index(wr_led, w_map_row, NUM_ROWS);

    // CLEAR zeroes both banks at the sweep index; COPY moves the front value
    // at the sweep index into the back bank; IDLE takes the pattern write.
    always_comb begin
        w_waddr = w_wr_idx;
        w_wdata = wr_value;
        if (r_state == ST_CLEAR) begin
            w_waddr = r_cnt;
            w_wdata = '0;
        end else if (r_state == ST_COPY) begin
            w_waddr = r_cnt;
            w_wdata = r_mem[r_front_sel][r_cnt];
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_bank_we
            // Only the back bank is ever written outside CLEAR, so the
            // scanner's frame can never change under it.
            assign w_we[gi] = (r_state == ST_CLEAR) ||
                              ((r_front_sel != 1'(gi)) &&
                               ((r_state == ST_COPY) || w_wr_good));
        end
    endgenerate

    always_ff @(posedge clk) begin
        for (int b = 0; b < 2; b++) begin
            if (w_we[b]) begin
                r_mem[b][w_waddr] <= w_wdata;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Scanner read port: registered, never stalled
    // -----------------------------------------------------------------------
    assign w_rd_in_range = (32'(rd_led) < 32'(NUM_LEDS)) &&
                           (32'(rd_row) < 32'(NUM_ROWS));
    assign w_rd_idx      = w_rd_in_range ? lin_index(rd_led, rd_row, NUM_ROWS) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_data <= '0;
        end else if ((r_state == ST_CLEAR) || !w_rd_in_range) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= r_mem[r_front_sel][w_rd_idx];
        end
    end

    assign wr_ready    = w_wr_ready;
    assign wr_err      = r_wr_err;
    assign commit_done = r_commit_done;
    assign rd_data     = r_rd_data;

endmodule

// File: tb/tb_led_frame_buffer.sv
// ---------------------------------------------------------------------------
// tb_led_frame_buffer
// Self-checking bench for led_frame_buffer. The reference model keeps the
// front and back frames as plain arrays and resolves colour->row from the
// per-LED order strings ("RGB", "BGR", "GRB"); a swap is modelled as an
// instant exchange followed by an instant copy.
// ---------------------------------------------------------------------------
module tb_led_frame_buffer;
    import led_pkg::*;

    localparam int NL    = DEFAULT_NUM_LEDS;
    localparam int NR    = DEFAULT_NUM_ROWS;
    localparam int DEPTH = NL * NR;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_valid = 1'b0;
    logic       wr_ready;
    logic [3:0] wr_led = '0;
    logic [1:0] wr_color = '0;
    logic [7:0] wr_value = '0;
    logic       wr_err;
    logic       commit = 1'b0;
    logic       commit_done;
    logic       frame_start = 1'b0;
    logic [3:0] rd_led = '0;
    logic [1:0] rd_row = '0;
    logic [7:0] rd_data;

    always #5 clk = ~clk;

    led_frame_buffer dut (
        .clk         (clk),
        .rst         (rst),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_led      (wr_led),
        .wr_color    (wr_color),
        .wr_value    (wr_value),
        .wr_err      (wr_err),
        .commit      (commit),
        .commit_done (commit_done),
        .frame_start (frame_start),
        .rd_led      (rd_led),
        .rd_row      (rd_row),
        .rd_data     (rd_data)
    );

    int total = 0;
    int bad   = 0;
    int done_count = 0;

    // Reference model
    int    model_front [DEPTH];
    int    model_back  [DEPTH];
    string order [NL] = '{"RGB", "BGR", "RGB", "BGR", "RGB", "BGR",
                          "BGR", "GRB", "GRB", "RGB", "RGB"};
    string letters = "RGB";

    always @(negedge clk) if (commit_done === 1'b1) done_count++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic int phys_row(input int led, input int color);
        string o;
        if (led < 0 || led >= NL || color < 0 || color > 2) return -1;
        o = order[led];
        for (int p = 0; p < NR; p++) begin
            if (o[p] == letters[color]) return p;
        end
        return -1;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) begin
            model_front[i] = 0;
            model_back[i]  = 0;
        end
    endtask

    task automatic model_swap();
        for (int i = 0; i < DEPTH; i++) model_front[i] = model_back[i];
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_chk(input int l, input int r, input string tag);
        int exp;
        rd_led = l[3:0];
        rd_row = r[1:0];
        tick();
        exp = (l < NL && r < NR) ? model_front[l*NR + r] : 0;
        chk($sformatf("%s(%0d,%0d)", tag, l, r), 32'(rd_data), exp);
    endtask

    task automatic rd_rand(input string tag);
        rd_chk(int'($urandom_range(0, 11)), int'($urandom_range(0, 3)), tag);
    endtask

    task automatic rd_all(input string tag);
        for (int l = 0; l < NL; l++)
            for (int r = 0; r < NR; r++)
                rd_chk(l, r, tag);
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (wr_ready !== 1'b1 && n < 100) begin
            rd_rand("busy_rd");
            n++;
        end
    endtask

    task automatic do_reset();
        int n;
        rst = 1'b1;
        wr_valid = 1'b0;
        commit = 1'b0;
        frame_start = 1'b0;
        tick();
        tick();
        chk("rst_wr_ready", 32'(wr_ready), 0);
        chk("rst_rd_data", 32'(rd_data), 0);
        chk("rst_commit_done", 32'(commit_done), 0);
        chk("rst_wr_err", 32'(wr_err), 0);
        model_clear();
        rst = 1'b0;
        wait_ready(n);
        chk("clear_len", n, DEPTH);
        $display("reset: ready after %0d cycles", n);
    endtask

    task automatic do_write(input int l, input int c, input int v, input bit with_commit);
        int r;
        r = phys_row(l, c);
        chk("wr_ready_before_write", 32'(wr_ready), 1);
        wr_valid = 1'b1;
        wr_led   = l[3:0];
        wr_color = c[1:0];
        wr_value = v[7:0];
        commit   = with_commit;
        tick();
        wr_valid = 1'b0;
        commit   = 1'b0;
        chk($sformatf("wr_err(l=%0d,c=%0d)", l, c), 32'(wr_err), (r < 0) ? 1 : 0);
        if (r >= 0) model_back[l*NR + r] = v & 255;
        $display("write led=%0d col=%0d val=0x%02h row=%0d commit=%0b", l, c, v & 255, r, with_commit);
    endtask

    task automatic do_commit();
        commit = 1'b1;
        tick();
        commit = 1'b0;
        $display("commit");
    endtask

    task automatic do_swap(input int delay, input bit extra_commit, input bit wait_copy);
        int d0;
        int n;
        d0 = done_count;
        for (int i = 0; i < delay; i++) begin
            commit = extra_commit && (i == 0);
            rd_rand("swap_wait_rd");
        end
        commit = 1'b0;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("commit_done_on_swap", 32'(commit_done), 1);
        model_swap();
        $display("swap after %0d cycles extra_commit=%0b", delay, extra_commit);
        if (wait_copy) begin
            wait_ready(n);
            chk("copy_len", n, DEPTH);
            chk("commit_done_count", done_count - d0, 1);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;

        // Reset and empty frame, plus out-of-range reads.
        do_reset();
        rd_all("init_rd");
        rd_chk(11, 0, "oob_rd");
        rd_chk(15, 2, "oob_rd");
        rd_chk(0, 3, "oob_rd");

        // First frame: LED1 red and LED7 green staged, front stays dark.
        do_write(1, 0, 'hFF, 1'b0);
        do_write(7, 1, 'h40, 1'b0);
        do_commit();
        rd_chk(7, 0, "pre_swap_rd");
        rd_chk(1, 2, "pre_swap_rd");
        do_swap(3, 1'b0, 1'b1);
        rd_all("frame1_rd");

        // Incremental write on top of the copied frame; extra commit ignored.
        do_write(0, 2, 'h10, 1'b0);
        do_commit();
        do_swap(2, 1'b1, 1'b1);
        rd_all("frame2_rd");

        // Bad writes are dropped; frame_start while idle does nothing.
        do_write(11, 0, 'h55, 1'b0);
        do_write(3, 3, 'h66, 1'b0);
        do_write(15, 1, 'h77, 1'b0);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("idle_frame_start_done", 32'(commit_done), 0);
        chk("idle_frame_start_ready", 32'(wr_ready), 1);
        do_write(9, 1, 'h21, 1'b1);
        do_swap(1, 1'b0, 1'b1);
        rd_all("frame3_rd");

        // Randomized frames.
        for (int rnd = 0; rnd < 5; rnd++) begin
            int nw;
            nw = int'($urandom_range(1, 6));
            for (int k = 0; k < nw; k++)
                do_write(int'($urandom_range(0, 12)), int'($urandom_range(0, 3)),
                         int'($urandom_range(0, 255)), 1'b0);
            do_write(int'($urandom_range(0, 10)), int'($urandom_range(0, 2)),
                     int'($urandom_range(0, 255)), 1'b1);
            do_swap(int'($urandom_range(1, 6)), 1'($urandom_range(0, 1)), 1'b1);
            for (int k = 0; k < 12; k++) rd_rand("rand_rd");
        end

        // Reset in the middle of COPY: everything is lost, no commit_done.
        do_write(4, 1, 'hAA, 1'b1);
        do_swap(2, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) rd_rand("copy_rd");
        d0 = done_count;
        do_reset();
        chk("no_done_after_rst", done_count - d0, 0);
        rd_all("post_rst_rd");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
